dotprod_host_ctrl: RTL and testbench

DOTPROD_HOST_CTRL -- requirements
Module: dotprod_host_ctrl

---
 rtl/dotprod_host_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_dotprod_host_ctrl.sv | 473 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dotprod_host_ctrl.sv
// dotprod_host_ctrl: host-side sequencer for a dot-product engine.
// Loads one batch of N vector pairs into the engine, lets it process, then
// reads every slot back and hands each result downstream with valid/ready.
`timescale 1ns/1ps
module dotprod_host_ctrl #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 12,
    parameter int PROC_CYCLES   = 90,
    parameter int RD_LATENCY    = 2    // must be at least 1
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_vec1,
    input  logic [DATA_WIDTH-1:0]     in_vec2,
    input  logic                      fsm_ready,
    output logic                      WR,
    output logic [ADDRESS_WIDTH-1:0]  wraddr,
    output logic [DATA_WIDTH-1:0]     dataIn1,
    output logic [DATA_WIDTH-1:0]     dataIn2,
    output logic                      startProcessing_rd,
    output logic                      RD,
    output logic [ADDRESS_WIDTH-1:0]  rdaddr,
    input  logic [2*DATA_WIDTH:0]     final_output,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [2*DATA_WIDTH:0]     res_data,
    output logic [ADDRESS_WIDTH-1:0]  res_addr,
    output logic                      res_last,
    output logic                      busy,
    output logic                      done
);

    localparam int N     = 2 ** ADDRESS_WIDTH;
    localparam int RES_W = 2 * DATA_WIDTH + 1;
    localparam int PCW   = $clog2(PROC_CYCLES + 2);
    localparam int LCW   = $clog2(RD_LATENCY + 2);

    localparam logic [ADDRESS_WIDTH-1:0] LAST_SLOT = ADDRESS_WIDTH'(N - 1);
    localparam logic [PCW-1:0]           PROC_END  = PCW'(PROC_CYCLES);
    localparam logic [LCW-1:0]           LAT_END   = LCW'(RD_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PROC,
        READ,
        WAIT_DATA,
        OUTPUT,
        DONE
    } state_t;

    state_t                   r_state;
    logic [ADDRESS_WIDTH-1:0] r_wr_cnt;
    logic [ADDRESS_WIDTH-1:0] r_rd_cnt;
    logic [PCW-1:0]           r_proc_cnt;
    logic [LCW-1:0]           r_lat_cnt;
    logic                     r_wr;
    logic [ADDRESS_WIDTH-1:0] r_wraddr;
    logic [DATA_WIDTH-1:0]    r_data_in1;
    logic [DATA_WIDTH-1:0]    r_data_in2;
    logic                     r_start_proc;
    logic                     r_rd;
    logic [ADDRESS_WIDTH-1:0] r_rdaddr;
    logic                     r_res_valid;
    logic [RES_W-1:0]         r_res_data;
    logic [ADDRESS_WIDTH-1:0] r_res_addr;
    logic                     r_res_last;
    logic                     r_busy;
    logic                     r_done;

    logic                     w_in_ready;
    logic                     w_accept;

    // Upstream handshake: ready only while loading and the engine can take a write.
    always_comb begin
        w_in_ready = (r_state == LOAD) && fsm_ready;
        w_accept   = w_in_ready && in_valid;
    end

    // Batch sequencer: every output is set on the transition that enters the state that owns it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= IDLE;
            r_wr_cnt     <= '0;
            r_rd_cnt     <= '0;
            r_proc_cnt   <= '0;
            r_lat_cnt    <= '0;
            r_wr         <= 1'b0;
            r_wraddr     <= '0;
            r_data_in1   <= '0;
            r_data_in2   <= '0;
            r_start_proc <= 1'b0;
            r_rd         <= 1'b0;
            r_rdaddr     <= '0;
            r_res_valid  <= 1'b0;
            r_res_data   <= '0;
            r_res_addr   <= '0;
            r_res_last   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_wr   <= 1'b0;
            r_rd   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state  <= LOAD;
                        r_wr_cnt <= '0;
                        r_busy   <= 1'b1;
                    end
                end
                LOAD: begin
                    if (w_accept) begin
                        r_wr       <= 1'b1;
                        r_wraddr   <= r_wr_cnt;
                        r_data_in1 <= in_vec1;
                        r_data_in2 <= in_vec2;
                        if (r_wr_cnt == LAST_SLOT) begin
                            r_state      <= PROC;
                            r_start_proc <= 1'b1;
                            r_proc_cnt   <= '0;
                        end else begin
                            r_wr_cnt <= r_wr_cnt + 1'b1;
                        end
                    end
                end
                PROC: begin
                    if (r_proc_cnt == PROC_END) begin
                        r_state  <= READ;
                        r_rd_cnt <= '0;
                        r_rd     <= 1'b1;
                        r_rdaddr <= '0;
                    end else begin
                        r_proc_cnt <= r_proc_cnt + 1'b1;
                    end
                end
                READ: begin
                    r_state   <= WAIT_DATA;
                    r_lat_cnt <= '0;
                end
                WAIT_DATA: begin
                    if (r_lat_cnt == LAT_END) begin
                        r_res_data  <= final_output;
                        r_res_addr  <= r_rdaddr;
                        r_res_last  <= (r_rdaddr == LAST_SLOT);
                        r_res_valid <= 1'b1;
                        r_state     <= OUTPUT;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 1'b1;
                    end
                end
                OUTPUT: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_res_last  <= 1'b0;
                        if (r_rd_cnt == LAST_SLOT) begin
                            r_state      <= DONE;
                            r_done       <= 1'b1;
                            r_start_proc <= 1'b0;
                        end else begin
                            r_rd_cnt <= r_rd_cnt + 1'b1;
                            r_rdaddr <= r_rd_cnt + 1'b1;
                            r_rd     <= 1'b1;
                            r_state  <= READ;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Drive the ports straight from the state registers.
    always_comb begin
        in_ready           = w_in_ready;
        WR                 = r_wr;
        wraddr             = r_wraddr;
        dataIn1            = r_data_in1;
        dataIn2            = r_data_in2;
        startProcessing_rd = r_start_proc;
        RD                 = r_rd;
        rdaddr             = r_rdaddr;
        res_valid          = r_res_valid;
        res_data           = r_res_data;
        res_addr           = r_res_addr;
        res_last           = r_res_last;
        busy               = r_busy;
        done               = r_done;
    end

endmodule

// File: tb/tb_dotprod_host_ctrl.sv
// tb_dotprod_host_ctrl: self-checking bench for dotprod_host_ctrl with a
// behavioural engine model and write/result scoreboards.
`timescale 1ns/1ps
module tb_dotprod_host_ctrl;

    localparam int AW = 5;
    localparam int DW = 12;
    localparam int PC = 90;
    localparam int RL = 2;
    localparam int N  = 32;
    localparam int RW = 2 * DW + 1;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          fsm_ready = 1'b0;
    logic          res_ready = 1'b0;
    logic [DW-1:0] in_vec1 = '0;
    logic [DW-1:0] in_vec2 = '0;
    logic [RW-1:0] final_output;

    logic          in_ready, WR, startProcessing_rd, RD, res_valid, res_last, busy, done;
    logic [AW-1:0] wraddr, rdaddr, res_addr;
    logic [DW-1:0] dataIn1, dataIn2;
    logic [RW-1:0] res_data;

    dotprod_host_ctrl #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .PROC_CYCLES(PC), .RD_LATENCY(RL)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_vec1(in_vec1), .in_vec2(in_vec2),
        .fsm_ready(fsm_ready), .WR(WR), .wraddr(wraddr), .dataIn1(dataIn1), .dataIn2(dataIn2),
        .startProcessing_rd(startProcessing_rd), .RD(RD), .rdaddr(rdaddr),
        .final_output(final_output),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_addr(res_addr), .res_last(res_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Three 4-bit elements per vector, element j in bits [4j+3:4j].
    function automatic logic [DW-1:0] vecOf(input int base);
        logic [3:0] e0, e1, e2;
        e0 = 4'(base);
        e1 = 4'(base + 1);
        e2 = 4'(base + 2);
        return {e2, e1, e0};
    endfunction

    function automatic logic [RW-1:0] dotOf(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [RW-1:0] acc;
        acc = '0;
        for (int j = 0; j < 3; j++) acc += RW'(a[4*j +: 4]) * RW'(b[4*j +: 4]);
        return acc;
    endfunction

    // Engine model: stores dot products on WR, returns them RL cycles after RD, junk otherwise.
    logic [RW-1:0] engMem  [N];
    logic [RW-1:0] engPipe [RL];
    always @(posedge clk) begin
        if (WR) engMem[wraddr] <= dotOf(dataIn1, dataIn2);
        engPipe[0] <= RD ? engMem[rdaddr] : RW'(25'h1ABCDE);
        for (int k = 1; k < RL; k++) engPipe[k] <= engPipe[k-1];
    end
    assign final_output = engPipe[RL-1];

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] v1;
        logic [DW-1:0] v2;
    } wrExp_t;
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [RW-1:0] data;
        logic          last;
    } resExp_t;

    wrExp_t  wrQ[$];
    resExp_t resQ[$];
    wrExp_t  monWr;
    resExp_t monRes;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int lastWrCyc = 0;
    int rdCyc = 0;
    int wrCount = 0;
    int rdCount = 0;
    int doneCount = 0;
    int lastCount = 0;
    int slot10Writes = 0;
    int rdExp = 0;
    bit firstRdSeen = 1'b0;
    bit prevResValid = 1'b0;
    logic [DW-1:0] slot0Vec1 = '0;
    logic [DW-1:0] slot0Vec2 = '0;
    logic [RW-1:0] slot0Res = '0;

    // Monitor: pops scoreboards on WR and on result transfers, and checks strobe timing.
    always @(negedge clk) begin
        cyc++;
        if (WR === 1'b1) begin
            wrCount++;
            lastWrCyc = cyc;
            if (wraddr == AW'(10)) slot10Writes++;
            if (wraddr == AW'(0)) begin
                slot0Vec1 = dataIn1;
                slot0Vec2 = dataIn2;
            end
            total++;
            if (wrQ.size() == 0) begin
                bad++;
                $display("[TB] FAIL wr_unexpected: got write addr=%0d, want no write", wraddr);
            end else begin
                monWr = wrQ.pop_front();
                if ({wraddr, dataIn1, dataIn2} !== monWr) begin
                    bad++;
                    $display("[TB] FAIL wr_data: got addr=%0d v1=%h v2=%h, want addr=%0d v1=%h v2=%h",
                             wraddr, dataIn1, dataIn2, monWr.addr, monWr.v1, monWr.v2);
                end
            end
        end
        if (RD === 1'b1) begin
            rdCount++;
            total++;
            if (rdaddr !== AW'(rdExp)) begin
                bad++;
                $display("[TB] FAIL rd_addr: got %0d, want %0d", rdaddr, rdExp);
            end
            rdExp++;
            if (!firstRdSeen) begin
                firstRdSeen = 1'b1;
                total++;
                if (cyc - lastWrCyc != PC + 1) begin
                    bad++;
                    $display("[TB] FAIL proc_gap: got %0d cycles, want %0d", cyc - lastWrCyc, PC + 1);
                end
            end
            rdCyc = cyc;
        end
        if (res_valid === 1'b1 && !prevResValid) begin
            total++;
            if (cyc - rdCyc != RL + 1) begin
                bad++;
                $display("[TB] FAIL rd_to_valid: got %0d cycles, want %0d", cyc - rdCyc, RL + 1);
            end
        end
        if (res_valid === 1'b1 && res_ready === 1'b1) begin
            if (res_addr == AW'(0)) slot0Res = res_data;
            if (res_last === 1'b1) lastCount++;
            total++;
            if (resQ.size() == 0) begin
                bad++;
                $display("[TB] FAIL res_unexpected: got addr=%0d data=%0d, want no result", res_addr, res_data);
            end else begin
                monRes = resQ.pop_front();
                if ({res_addr, res_data, res_last} !== monRes) begin
                    bad++;
                    $display("[TB] FAIL res_data: got addr=%0d data=%0d last=%b, want addr=%0d data=%0d last=%b",
                             res_addr, res_data, res_last, monRes.addr, monRes.data, monRes.last);
                end
            end
        end
        if (done === 1'b1) doneCount++;
        prevResValid = (res_valid === 1'b1);
    end

    // Clears per-batch bookkeeping and issues a one-cycle start.
    task automatic beginBatch();
        wrQ.delete();
        resQ.delete();
        wrCount = 0;
        rdCount = 0;
        doneCount = 0;
        lastCount = 0;
        slot10Writes = 0;
        rdExp = 0;
        firstRdSeen = 1'b0;
        fsm_ready = 1'b1;
        res_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Presents N pairs, optionally stalling fsm_ready before stallSlot and pulsing start at noiseSlot.
    task automatic applyStimulus(input int off, input int stallSlot, input int stallLen, input int noiseSlot);
        wrExp_t we;
        resExp_t re;
        int waitCyc;
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1;
            in_vec1 = vecOf(3 * i + off);
            in_vec2 = vecOf(3 * i + off + 2);
            if (i == noiseSlot) start = 1'b1;
            if (i == stallSlot) begin
                fsm_ready = 1'b0;
                for (int k = 0; k < stallLen; k++) begin
                    @(negedge clk);
                    total++;
                    if (in_ready !== 1'b0) begin
                        bad++;
                        $display("[TB] FAIL stall_in_ready: got %b, want 0", in_ready);
                    end
                    if (k > 0) begin
                        total++;
                        if (WR !== 1'b0) begin
                            bad++;
                            $display("[TB] FAIL stall_wr: got %b, want 0", WR);
                        end
                    end
                    @(posedge clk); #1;
                end
                fsm_ready = 1'b1;
            end
            waitCyc = 0;
            do begin
                @(negedge clk);
                waitCyc++;
            end while (in_ready !== 1'b1 && waitCyc < 100);
            if (in_ready !== 1'b1) begin
                total++;
                bad++;
                $display("[TB] FAIL accept_timeout: slot %0d not accepted, in_ready=%b want 1", i, in_ready);
                in_valid = 1'b0;
                start = 1'b0;
                return;
            end
            we.addr = AW'(i);
            we.v1 = in_vec1;
            we.v2 = in_vec2;
            wrQ.push_back(we);
            re.addr = AW'(i);
            re.data = dotOf(in_vec1, in_vec2);
            re.last = (i == N - 1);
            resQ.push_back(re);
            @(posedge clk); #1;
            start = 1'b0;
        end
        in_valid = 1'b0;
    endtask

    // Waits for done with a cycle budget; optionally raises start during the DONE cycle.
    task automatic waitBatchEnd(input bit pulseAtDone);
        int waitCyc;
        waitCyc = 0;
        do begin
            @(negedge clk);
            waitCyc++;
        end while (done !== 1'b1 && waitCyc < 3000);
        if (done !== 1'b1) begin
            total++;
            bad++;
            $display("[TB] FAIL batch_timeout: done=%b after %0d cycles, want 1", done, waitCyc);
        end else if (pulseAtDone) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        repeat (3) @(negedge clk);
        total++;
        if ({in_ready, WR, wraddr, dataIn1, dataIn2, startProcessing_rd} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_write_side: got %h, want 0", {in_ready, WR, wraddr, dataIn1, dataIn2, startProcessing_rd});
        end
        total++;
        if ({RD, rdaddr, res_valid, res_data, res_addr, res_last} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_read_side: got %h, want 0", {RD, rdaddr, res_valid, res_data, res_addr, res_last});
        end
        total++;
        if ({busy, done} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL reset_status: got busy=%b done=%b, want 0 0", busy, done);
        end
        rstn = 1'b1;
        fsm_ready = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({in_ready, busy, WR} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL idle_after_reset: got in_ready=%b busy=%b WR=%b, want 0 0 0", in_ready, busy, WR);
        end
    endtask

    task automatic test_basic_batch();
        $display("[TB] test_basic_batch");
        beginBatch();
        applyStimulus(0, -1, 0, -1);
        waitBatchEnd(1'b0);
        total++;
        if (wrCount != N || rdCount != N) begin
            bad++;
            $display("[TB] FAIL basic_counts: got wr=%0d rd=%0d, want %0d %0d", wrCount, rdCount, N, N);
        end
        total++;
        if (doneCount != 1 || lastCount != 1) begin
            bad++;
            $display("[TB] FAIL basic_done_last: got done=%0d last=%0d, want 1 1", doneCount, lastCount);
        end
        total++;
        if (slot0Vec1 !== 12'h210 || slot0Vec2 !== 12'h432) begin
            bad++;
            $display("[TB] FAIL basic_slot0_data: got %h %h, want 210 432", slot0Vec1, slot0Vec2);
        end
        total++;
        if (slot0Res !== RW'(11)) begin
            bad++;
            $display("[TB] FAIL basic_slot0_result: got %0d, want 11", slot0Res);
        end
        total++;
        if (resQ.size() != 0 || wrQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL basic_leftover: got wrQ=%0d resQ=%0d, want 0 0", wrQ.size(), resQ.size());
        end
    endtask

    task automatic test_write_stall();
        $display("[TB] test_write_stall");
        beginBatch();
        applyStimulus(4, 10, 5, -1);
        waitBatchEnd(1'b0);
        total++;
        if (slot10Writes != 1 || wrCount != N) begin
            bad++;
            $display("[TB] FAIL stall_writes: got slot10=%0d total=%0d, want 1 %0d", slot10Writes, wrCount, N);
        end
        total++;
        if (resQ.size() != 0 || doneCount != 1) begin
            bad++;
            $display("[TB] FAIL stall_results: got resQ=%0d done=%0d, want 0 1", resQ.size(), doneCount);
        end
    endtask

    task automatic test_backpressure();
        int waitCyc;
        logic [RW-1:0] expData;
        $display("[TB] test_backpressure");
        beginBatch();
        applyStimulus(7, -1, 0, -1);
        expData = dotOf(vecOf(3 * 3 + 7), vecOf(3 * 3 + 9));
        waitCyc = 0;
        do begin
            @(negedge clk);
            waitCyc++;
        end while (!(res_valid === 1'b1 && res_addr === AW'(2)) && waitCyc < 1000);
        @(posedge clk); #1;
        res_ready = 1'b0;
        waitCyc = 0;
        do begin
            @(negedge clk);
            waitCyc++;
        end while (res_valid !== 1'b1 && waitCyc < 20);
        for (int k = 0; k < 7; k++) begin
            if (k > 0) @(negedge clk);
            total++;
            if ({res_valid, res_addr, res_data} !== {1'b1, AW'(3), expData}) begin
                bad++;
                $display("[TB] FAIL bp_hold: got valid=%b addr=%0d data=%0d, want 1 3 %0d",
                         res_valid, res_addr, res_data, expData);
            end
            total++;
            if (RD !== 1'b0) begin
                bad++;
                $display("[TB] FAIL bp_rd: got %b, want 0", RD);
            end
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        waitBatchEnd(1'b0);
        total++;
        if (resQ.size() != 0 || rdCount != N || doneCount != 1) begin
            bad++;
            $display("[TB] FAIL bp_complete: got resQ=%0d rd=%0d done=%0d, want 0 %0d 1",
                     resQ.size(), rdCount, doneCount, N);
        end
    endtask

    task automatic test_reset_mid_read();
        int waitCyc;
        $display("[TB] test_reset_mid_read");
        beginBatch();
        applyStimulus(11, -1, 0, -1);
        waitCyc = 0;
        do begin
            @(negedge clk);
            waitCyc++;
        end while (!(RD === 1'b1 && rdaddr === AW'(12)) && waitCyc < 1000);
        #2;
        rstn = 1'b0;
        #1;
        total++;
        if ({in_ready, WR, wraddr, dataIn1, dataIn2, startProcessing_rd, RD, rdaddr,
             res_valid, res_data, res_addr, res_last, done} !== '0) begin
            bad++;
            $display("[TB] FAIL midreset_outputs: got %h, want 0",
                     {in_ready, WR, wraddr, dataIn1, dataIn2, startProcessing_rd, RD, rdaddr,
                      res_valid, res_data, res_addr, res_last, done});
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midreset_busy: got %b, want 0", busy);
        end
        wrQ.delete();
        resQ.delete();
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            total++;
            if ({WR, RD, busy} !== 3'b000) begin
                bad++;
                $display("[TB] FAIL midreset_quiet: got WR=%b RD=%b busy=%b, want 0 0 0", WR, RD, busy);
            end
        end
        beginBatch();
        applyStimulus(13, -1, 0, -1);
        waitBatchEnd(1'b0);
        total++;
        if (wrCount != N || rdCount != N || doneCount != 1 || resQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL midreset_rerun: got wr=%0d rd=%0d done=%0d resQ=%0d, want %0d %0d 1 0",
                     wrCount, rdCount, doneCount, resQ.size(), N, N);
        end
    endtask

    task automatic test_start_ignored();
        $display("[TB] test_start_ignored");
        beginBatch();
        applyStimulus(20, -1, 0, 6);
        repeat (20) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        waitBatchEnd(1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if ({busy, WR} !== 2'b00) begin
                bad++;
                $display("[TB] FAIL start_ignored_idle: got busy=%b WR=%b, want 0 0", busy, WR);
            end
        end
        total++;
        if (doneCount != 1 || wrCount != N || rdCount != N) begin
            bad++;
            $display("[TB] FAIL start_ignored_counts: got done=%0d wr=%0d rd=%0d, want 1 %0d %0d",
                     doneCount, wrCount, rdCount, N, N);
        end
    endtask

    initial begin
        test_reset();
        test_basic_batch();
        test_write_stall();
        test_backpressure();
        test_reset_mid_read();
        test_start_ignored();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
